minmax_window_ctrl: RTL and testbench

//  Streaming controller that sequences a shared 3-input max/min/diff datapath over windows of
//  WIN samples. Each accepted sample is folded into a running max/min, so the whole window is

---
 rtl/minmax_pkg.sv | 16 +
 rtl/minmax3_unit.sv | 26 ++
 rtl/minmax_window_ctrl.sv | 130 +++++++++++++
 tb/tb_minmax_window_ctrl.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/minmax_pkg.sv
// Shared types and constants for the windowed max/min controller.
package minmax_pkg;

  localparam int unsigned SAMPLE_W = 8;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  typedef enum logic [1:0] {
    StEmpty = ST_EMPTY,
    StAccum = ST_ACCUM,
    StDone  = ST_DONE
  } state_e;

endpackage

// File: rtl/minmax3_unit.sv
// Combinational 3-input unsigned max/min with max-min difference.
module minmax3_unit
  import minmax_pkg::*;
(
  input  logic [SAMPLE_W-1:0] a,
  input  logic [SAMPLE_W-1:0] b,
  input  logic [SAMPLE_W-1:0] c,
  output logic [SAMPLE_W-1:0] max,
  output logic [SAMPLE_W-1:0] min,
  output logic [SAMPLE_W-1:0] diff
);

  logic [SAMPLE_W-1:0] hi_ab, lo_ab, hi, lo;

  always_comb begin
    hi_ab = (a > b) ? a : b;
    lo_ab = (a < b) ? a : b;
    hi    = (hi_ab > c) ? hi_ab : c;
    lo    = (lo_ab < c) ? lo_ab : c;
  end

  assign max  = hi;
  assign min  = lo;
  assign diff = hi - lo;

endmodule

// File: rtl/minmax_window_ctrl.sv
// Folds accepted samples into a running max/min and publishes {max, min, diff, count}
// per window of WIN samples (or earlier on flush) over a valid/ready result port.
module minmax_window_ctrl
  import minmax_pkg::*;
#(
  parameter int unsigned WIN = 8,
  parameter int unsigned CW  = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SAMPLE_W-1:0] in_data,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                flush,
  output logic [SAMPLE_W-1:0] out_max,
  output logic [SAMPLE_W-1:0] out_min,
  output logic [SAMPLE_W-1:0] out_diff,
  output logic [CW-1:0]       count_out,
  output logic                out_valid,
  input  logic                out_ready
);

  localparam logic [CW-1:0] WinC = CW'(WIN);

  state_e              state_q, state_d;
  logic [SAMPLE_W-1:0] run_max_q, run_max_d, run_min_q, run_min_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [SAMPLE_W-1:0] res_max_q, res_max_d, res_min_q, res_min_d, res_diff_q, res_diff_d;
  logic [CW-1:0]       res_cnt_q, res_cnt_d;

  logic [SAMPLE_W-1:0] unit_a, unit_b, unit_c, unit_max, unit_min, unit_diff;
  logic [CW-1:0]       cnt_inc;
  logic                accept, close;

  minmax3_unit u_unit (
    .a    (unit_a),
    .b    (unit_b),
    .c    (unit_c),
    .max  (unit_max),
    .min  (unit_min),
    .diff (unit_diff)
  );

  always_comb begin
    state_d    = state_q;
    run_max_d  = run_max_q;
    run_min_d  = run_min_q;
    cnt_d      = cnt_q;
    res_max_d  = res_max_q;
    res_min_d  = res_min_q;
    res_diff_d = res_diff_q;
    res_cnt_d  = res_cnt_q;
    in_ready   = (state_q != StDone);
    out_valid  = (state_q == StDone);
    accept     = in_valid && in_ready;
    cnt_inc    = cnt_q + 1'b1;
    close      = 1'b0;
    // Idle feed of run_max into c leaves the unit reporting the window as-is on a bare flush.
    unit_a     = run_max_q;
    unit_b     = run_min_q;
    unit_c     = run_max_q;

    unique case (state_q)
      StEmpty: begin
        unit_a = in_data;
        unit_b = in_data;
        unit_c = in_data;
        if (accept) begin
          run_max_d = unit_max;
          run_min_d = unit_min;
          cnt_d     = cnt_inc;
          state_d   = StAccum;
          close     = flush || (cnt_inc == WinC);
        end
      end
      StAccum: begin
        if (accept) begin
          unit_c    = in_data;
          run_max_d = unit_max;
          run_min_d = unit_min;
          cnt_d     = cnt_inc;
        end
        close = flush || (accept && (cnt_inc == WinC));
      end
      StDone: begin
        if (out_ready) begin
          state_d = StEmpty;
          cnt_d   = '0;
        end
      end
      default: state_d = StEmpty;
    endcase

    if (close) begin
      state_d    = StDone;
      res_max_d  = unit_max;
      res_min_d  = unit_min;
      res_diff_d = unit_diff;
      res_cnt_d  = accept ? cnt_inc : cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StEmpty;
      run_max_q  <= '0;
      run_min_q  <= '0;
      cnt_q      <= '0;
      res_max_q  <= '0;
      res_min_q  <= '0;
      res_diff_q <= '0;
      res_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      run_max_q  <= run_max_d;
      run_min_q  <= run_min_d;
      cnt_q      <= cnt_d;
      res_max_q  <= res_max_d;
      res_min_q  <= res_min_d;
      res_diff_q <= res_diff_d;
      res_cnt_q  <= res_cnt_d;
    end
  end

  assign out_max   = res_max_q;
  assign out_min   = res_min_q;
  assign out_diff  = res_diff_q;
  assign count_out = res_cnt_q;

endmodule

// File: tb/tb_minmax_window_ctrl.sv
// Directed and randomized bench for minmax_window_ctrl against a queue-based window model.
module tb_minmax_window_ctrl;

  localparam int unsigned WIN = 8;
  localparam int unsigned CW  = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic          flush;
  logic [7:0]    out_max, out_min, out_diff;
  logic [CW-1:0] count_out;
  logic          out_valid;
  logic          out_ready;

  always #5 clk = ~clk;

  minmax_window_ctrl #(
    .WIN (WIN),
    .CW  (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .flush     (flush),
    .out_max   (out_max),
    .out_min   (out_min),
    .out_diff  (out_diff),
    .count_out (count_out),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  // Reference model: samples of the open window, plus the pending result.
  logic [7:0] win_q[$];
  bit         pend     = 1'b0;
  bit         rst_prev = 1'b0;
  int         e_max, e_min, e_cnt;
  int         closes   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic close_window();
    e_max = 0;
    e_min = 255;
    foreach (win_q[i]) begin
      if (int'(win_q[i]) > e_max) e_max = int'(win_q[i]);
      if (int'(win_q[i]) < e_min) e_min = int'(win_q[i]);
    end
    e_cnt = win_q.size();
    win_q.delete();
    pend = 1'b1;
    closes++;
  endtask

  task automatic cyc(input bit r, input bit v, input logic [7:0] d, input bit f, input bit o);
    @(negedge clk);
    rst       = r;
    in_valid  = v;
    in_data   = d;
    flush     = f;
    out_ready = o;
    #1;
    check("in_ready", {31'd0, in_ready}, {31'd0, !pend});
    check("out_valid", {31'd0, out_valid}, {31'd0, pend});
    if (rst_prev) begin
      check("rst_max", {24'd0, out_max}, 0);
      check("rst_min", {24'd0, out_min}, 0);
      check("rst_diff", {24'd0, out_diff}, 0);
      check("rst_count", {24'd0, count_out}, 0);
    end
    if (pend) begin
      check("max", {24'd0, out_max}, e_max);
      check("min", {24'd0, out_min}, e_min);
      check("diff", {24'd0, out_diff}, e_max - e_min);
      check("count", {24'd0, count_out}, e_cnt);
      check("min_le_max", {31'd0, out_min <= out_max}, 1);
    end
    rst_prev = r;
    if (r) begin
      pend = 1'b0;
      win_q.delete();
    end else if (pend) begin
      if (o) pend = 1'b0;
    end else begin
      if (v) win_q.push_back(d);
      if (win_q.size() > 0 && (f || win_q.size() == WIN)) close_window();
    end
  endtask

  task automatic feed(input logic [7:0] d, input bit o);
    cyc(1'b0, 1'b1, d, 1'b0, o);
  endtask

  logic [7:0] t1[8] = '{8'd5, 8'd200, 8'd17, 8'd0, 8'd99, 8'd255, 8'd3, 8'd42};
  int cycles;
  int closes_before;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; flush = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_prev = 1'b1;

    // 1: full window, immediate consume
    foreach (t1[i]) feed(t1[i], 1'b1);
    repeat (3) cyc(1'b0, 1'b0, 8'hAA, 1'b0, 1'b1);

    // 2: flush together with the fourth sample, then a bare flush while empty
    feed(8'd10, 1'b1); feed(8'd12, 1'b1); feed(8'd11, 1'b1);
    cyc(1'b0, 1'b1, 8'd9, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 8'd0, 1'b0, 1'b1);
    closes_before = closes;
    cyc(1'b0, 1'b0, 8'd77, 1'b1, 1'b1);
    repeat (2) cyc(1'b0, 1'b0, 8'd0, 1'b0, 1'b1);
    check("flush_empty_no_result", closes - closes_before, 0);

    // 3: backpressure for 5 cycles with samples offered
    for (int i = 0; i < 8; i++) feed(8'(i * 30 + 7), 1'b0);
    repeat (5) cyc(1'b0, 1'b1, 8'hEE, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 8'hEE, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) feed(8'(100 - i), 1'b1);
    cyc(1'b0, 1'b0, 8'd0, 1'b0, 1'b1);

    // 4: all-equal window, then single-sample flush
    repeat (8) feed(8'h80, 1'b1);
    cyc(1'b0, 1'b0, 8'd0, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 8'd0, 1'b0, 1'b1);

    // 5: reset mid-window and in DONE
    for (int i = 0; i < 4; i++) feed(8'(250 - i), 1'b1);
    cyc(1'b1, 1'b0, 8'd0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) feed(8'(i + 1), 1'b0);
    cyc(1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 8'd0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) feed(8'(40 + i), 1'b1);
    cyc(1'b0, 1'b0, 8'd0, 1'b0, 1'b1);

    // 6: random traffic over 1000 windows
    closes_before = closes;
    cycles = 0;
    while (closes - closes_before < 1000 && cycles < 60000) begin
      cyc($urandom_range(0, 799) == 0, $urandom_range(0, 9) < 7, 8'($urandom),
          $urandom_range(0, 19) == 0, $urandom_range(0, 1) == 1);
      cycles++;
    end
    if (cycles >= 60000) check("random_budget", 0, 1);
    repeat (20) cyc(1'b0, 1'b0, 8'd0, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
